// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
//   state_t : scheduler FSM states
//   ch_w(n) : bit width of a channel index for n channels
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Channel-index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder.
//   req       : request vector, one bit per channel
//   ptr       : channel with highest priority this decision
//   gnt_valid : at least one request is set
//   gnt_idx   : first requesting channel at or after ptr, wrapping modulo N
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  // idx[k] is the channel sitting k places after ptr in the rotation.
  logic [W-1:0] idx [N];
  logic [N-1:0] hit;

  for (genvar k = 0; k < N; k++) begin : g_rot
    logic [W:0] sum;
    assign sum    = {1'b0, ptr} + (W+1)'(k);
    assign idx[k] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
    assign hit[k] = req[idx[k]];
  end

  // Walk from the lowest-priority slot up so the closest hit to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[k];
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one decimating FIR engine among NUM_CH sample streams.
// Channels are granted round robin; a grant feeds exactly DECIMATION input
// samples to the engine, then steers the one resulting output word into that
// channel's output FIFO.
//   clock, reset           : clock, synchronous active-high reset
//   in_empty/in_dout/in_rd_en   : per-channel input FIFO read side
//   out_full/out_din/out_wr_en  : per-channel output FIFO write side (shared data)
//   fir_x_din/fir_x_empty/fir_x_rd_en : sample stream into the engine
//   fir_y_dout/fir_y_wr_en/fir_y_full : result stream out of the engine
//   fir_ch    : active channel, selects the engine's history bank
//   busy      : scheduler not idle
//   proto_err : sticky engine-handshake violation, cleared by reset only
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH     = 3,
  parameter  int DECIMATION = 8,
  parameter  int DATA_SIZE  = 32,
  localparam int CW         = ch_w(NUM_CH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_empty,
  input  logic [NUM_CH*DATA_SIZE-1:0] in_dout,
  output logic [NUM_CH-1:0]           in_rd_en,
  input  logic [NUM_CH-1:0]           out_full,
  output logic [DATA_SIZE-1:0]        out_din,
  output logic [NUM_CH-1:0]           out_wr_en,
  output logic [DATA_SIZE-1:0]        fir_x_din,
  output logic                        fir_x_empty,
  input  logic                        fir_x_rd_en,
  output logic [CW-1:0]               fir_ch,
  input  logic [DATA_SIZE-1:0]        fir_y_dout,
  input  logic                        fir_y_wr_en,
  output logic                        fir_y_full,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int CNTW = $clog2(DECIMATION + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DECIMATION - 1);

  state_t          state;
  logic [CW-1:0]   g;
  logic [CW-1:0]   rr_ptr;
  logic [CNTW-1:0] cnt;

  logic [DATA_SIZE-1:0] din_a [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign din_a[i] = in_dout[i*DATA_SIZE +: DATA_SIZE];
  end

  // A channel only competes if it can both supply a block and take the result.
  logic [NUM_CH-1:0] eligible;
  logic              gnt_valid;
  logic [CW-1:0]     gnt_idx;

  assign eligible = ~in_empty & ~out_full;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Engine-facing steering; everything is quiet outside the active phase.
  always_comb begin
    in_rd_en    = '0;
    out_wr_en   = '0;
    out_din     = '0;
    fir_x_din   = '0;
    fir_x_empty = 1'b1;
    fir_y_full  = 1'b1;
    unique case (state)
      FEED: begin
        fir_x_din   = din_a[g];
        fir_x_empty = in_empty[g];
        in_rd_en[g] = fir_x_rd_en & ~in_empty[g];
      end
      DRAIN: begin
        fir_y_full   = out_full[g];
        out_din      = fir_y_dout;
        out_wr_en[g] = fir_y_wr_en & ~out_full[g];
      end
      default: ;
    endcase
  end

  logic rd_acc, wr_acc, y_spurious, x_spurious;
  assign rd_acc     = (state == FEED)  & fir_x_rd_en & ~in_empty[g];
  assign wr_acc     = (state == DRAIN) & fir_y_wr_en & ~out_full[g];
  assign y_spurious = fir_y_wr_en & (state != DRAIN);
  assign x_spurious = fir_x_rd_en & fir_x_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      if (y_spurious || x_spurious) proto_err <= 1'b1;
      unique case (state)
        IDLE: if (gnt_valid) begin
          g     <= gnt_idx;
          cnt   <= '0;
          state <= FEED;
        end
        // Grant is held through input underruns; the block never splits.
        FEED: if (rd_acc) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DRAIN;
        end
        // Pointer moves past the served channel, so it goes to the back.
        DRAIN: if (wr_acc) begin
          rr_ptr <= (g == CW'(NUM_CH - 1)) ? '0 : g + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fir_ch = g;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed/randomised bench: FIFO and engine models around the scheduler,
// expected results computed from block sums of the samples pushed.
module tb_fir_channel_scheduler;
  localparam int NCH = 3;
  localparam int DEC = 8;
  localparam int DS  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0]    in_empty, in_rd_en, out_full, out_wr_en;
  logic [NCH*DS-1:0] in_dout;
  logic [DS-1:0]     out_din, fir_x_din, fir_y_dout;
  logic              fir_x_empty, fir_x_rd_en, fir_y_wr_en, fir_y_full, busy, proto_err;
  logic [1:0]        fir_ch;

  always #5 clock = ~clock;

  fir_channel_scheduler #(.NUM_CH(NCH), .DECIMATION(DEC), .DATA_SIZE(DS)) dut (
    .clock(clock), .reset(reset),
    .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .out_full(out_full), .out_din(out_din), .out_wr_en(out_wr_en),
    .fir_x_din(fir_x_din), .fir_x_empty(fir_x_empty), .fir_x_rd_en(fir_x_rd_en),
    .fir_ch(fir_ch), .fir_y_dout(fir_y_dout), .fir_y_wr_en(fir_y_wr_en),
    .fir_y_full(fir_y_full), .busy(busy), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Input FIFO models: mem written by the stimulus, rp advanced on reads.
  logic [DS-1:0] mem [NCH][64];
  int            wp [NCH];
  int            rp [NCH];
  int            rd_cnt [NCH];
  int            wr_total;
  logic [DS-1:0] outq [NCH][$];
  int            grants [$];
  logic [NCH-1:0] force_full = '0;
  logic eng_pop_en = 1'b1, eng_const = 1'b0, x_spur = 1'b0, y_spur = 1'b0;

  // Engine model: pops DEC samples, returns their sum 4 cycles later.
  int            ecnt, elat;
  logic [DS-1:0] eacc;
  logic          evalid;
  logic          busy_q;
  logic [NCH-1:0] sel;

  for (genvar i = 0; i < NCH; i++) begin : g_fifo
    assign in_empty[i]         = (rp[i] == wp[i]);
    assign in_dout[i*DS +: DS] = mem[i][rp[i] % 64];
  end
  assign out_full    = force_full;
  assign fir_x_rd_en = (eng_pop_en && ecnt < DEC && !fir_x_empty) || x_spur;
  assign fir_y_wr_en = evalid | y_spur;
  assign fir_y_dout  = eng_const ? 32'hAB : eacc;
  assign sel         = NCH'(1) << fir_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        rp[i] <= 0;
        rd_cnt[i] <= 0;
        outq[i].delete();
      end
      wr_total <= 0;
      ecnt <= 0; elat <= 0; eacc <= '0; evalid <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_rd_en[i]) begin
          rp[i] <= rp[i] + 1;
          rd_cnt[i] <= rd_cnt[i] + 1;
        end
        if (out_wr_en[i]) begin
          outq[i].push_back(out_din);
          wr_total <= wr_total + 1;
        end
      end
      if (fir_x_rd_en && !fir_x_empty) begin
        eacc <= eacc + fir_x_din;
        ecnt <= ecnt + 1;
        if (ecnt == DEC - 1) elat <= 4;
      end
      if (elat != 0) begin
        elat <= elat - 1;
        if (elat == 1) evalid <= 1'b1;
      end
      if (evalid && !fir_y_full) begin
        evalid <= 1'b0; ecnt <= 0; eacc <= '0;
      end
    end
  end

  // Grant log plus the invariant that only the active channel strobes.
  always @(negedge clock) begin
    if (reset) begin
      grants.delete();
      busy_q <= 1'b0;
    end else begin
      if (busy && !busy_q) grants.push_back(int'(fir_ch));
      busy_q <= busy;
      if (busy) chk("strobe_on_other_ch", {in_rd_en, out_wr_en} & ~{sel, sel}, 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input int ch, input logic [DS-1:0] v);
    mem[ch][wp[ch] % 64] = v;
    wp[ch]++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) wp[i] = 0;
    force_full = '0; x_spur = 1'b0; y_spur = 1'b0; eng_pop_en = 1'b1; eng_const = 1'b0;
    cyc(2);
    chk("reset_state", {busy, proto_err, fir_ch}, 0);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_total < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk(tag, wr_total >= n, 1);
  endtask

  function automatic logic [DS-1:0] blk_sum(input int ch, input int first);
    logic [DS-1:0] s = '0;
    for (int j = 0; j < DEC; j++) s += mem[ch][(first + j) % 64];
    return s;
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 64; j++) mem[i][j] = '0;

    // 1: idle with every input empty
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      chk("idle_outputs", {busy, in_rd_en, out_wr_en, fir_x_empty, fir_y_full, fir_ch, proto_err},
          {1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0});
    end

    // 2: single block on ch1, constant engine result
    do_reset();
    eng_const = 1'b1;
    for (int v = 1; v <= 8; v++) push(1, DS'(v));
    cyc(1);
    chk("t2_grant_latency", {busy, fir_ch}, {1'b1, 2'd1});
    wait_writes(1, 100, "t2_timeout");
    chk("t2_ngrants", grants.size(), 1);
    chk("t2_grant_ch", grants[0], 1);
    chk("t2_rd_ch1", rd_cnt[1], 8);
    chk("t2_rd_other", rd_cnt[0] + rd_cnt[2], 0);
    chk("t2_wr_ch1", outq[1].size(), 1);
    chk("t2_dout", outq[1][0], 32'hAB);
    // rr_ptr now points at ch2, so ch2 beats ch0
    eng_const = 1'b0;
    for (int j = 0; j < DEC; j++) begin
      push(0, $urandom);
      push(2, $urandom);
    end
    wait_writes(3, 200, "t2b_timeout");
    chk("t2b_first", grants[1], 2);
    chk("t2b_second", grants[2], 0);
    chk("t2b_out2", outq[2][0], blk_sum(2, 0));
    chk("t2b_out0", outq[0][0], blk_sum(0, 0));
    chk("t2_proto", proto_err, 0);

    // 3: all channels busy for six blocks
    do_reset();
    for (int j = 0; j < 2 * DEC; j++)
      for (int ch = 0; ch < NCH; ch++) push(ch, $urandom);
    wait_writes(6, 400, "t3_timeout");
    for (int k = 0; k < 6; k++) chk("t3_order", grants[k], k % NCH);
    for (int ch = 0; ch < NCH; ch++) begin
      chk("t3_nout", outq[ch].size(), 2);
      chk("t3_out_a", outq[ch][0], blk_sum(ch, 0));
      chk("t3_out_b", outq[ch][1], blk_sum(ch, DEC));
      chk("t3_rd", rd_cnt[ch], 2 * DEC);
    end

    // 4: underrun mid-block holds the grant
    do_reset();
    for (int j = 0; j < 3; j++) push(0, $urandom);
    for (int j = 0; j < DEC; j++) push(2, $urandom);
    cyc(4);
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk("t4_hold", {busy, fir_ch, in_rd_en}, {1'b1, 2'd0, 3'b000});
    end
    for (int j = 0; j < 5; j++) push(0, $urandom);
    wait_writes(2, 200, "t4_timeout");
    chk("t4_ngrants", grants.size(), 2);
    chk("t4_first", grants[0], 0);
    chk("t4_second", grants[1], 2);
    chk("t4_rd0", rd_cnt[0], DEC);
    chk("t4_out0", outq[0][0], blk_sum(0, 0));
    chk("t4_out2", outq[2][0], blk_sum(2, 0));

    // 5: output back-pressure during DRAIN
    do_reset();
    for (int j = 0; j < DEC; j++) push(0, $urandom);
    begin
      int k = 0;
      while (rd_cnt[0] < DEC && k < 100) begin cyc(1); k++; end
      chk("t5_feed_timeout", rd_cnt[0], DEC);
      force_full[0] = 1'b1;
      k = 0;
      while (!evalid && k < 100) begin cyc(1); k++; end
      chk("t5_engine_timeout", evalid, 1);
    end
    for (int c = 0; c < 5; c++) begin
      chk("t5_backpressure", {fir_y_full, out_wr_en, busy}, {1'b1, 3'b000, 1'b1});
      cyc(1);
    end
    force_full[0] = 1'b0;
    #1;
    chk("t5_release_wr", out_wr_en, 3'b001);
    cyc(1);
    chk("t5_nout", outq[0].size(), 1);
    chk("t5_out", outq[0][0], blk_sum(0, 0));
    chk("t5_idle", busy, 0);

    // 6: protocol errors and reset mid-block
    do_reset();
    eng_pop_en = 1'b0;
    for (int j = 0; j < DEC; j++) push(0, $urandom);
    cyc(1);
    chk("t6_feed", busy, 1);
    y_spur = 1'b1;
    #1;
    chk("t6_no_wr", out_wr_en, 0);
    cyc(1);
    y_spur = 1'b0;
    chk("t6_yerr", proto_err, 1);
    cyc(3);
    chk("t6_sticky", proto_err, 1);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) wp[i] = 0;
    cyc(1);
    chk("t6_reset", {busy, proto_err, fir_ch}, 0);
    reset = 1'b0;
    cyc(1);
    x_spur = 1'b1;
    cyc(1);
    x_spur = 1'b0;
    chk("t6_xerr", {busy, proto_err}, {1'b0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
- Time-shares one decimating FIR engine among NUM_CH sample streams (e.g. L+R, L-R and pilot paths in the stereo demodulator).
- Each channel has its own input FIFO and output FIFO. The scheduler grants one channel at a time, in round robin.
- A grant streams exactly DECIMATION samples into the engine, then routes the single resulting output word to that channel's output FIFO.
- The engine keeps per-channel tap history banked by fir_ch. The scheduler only sequences and steers.

Parameters:
- NUM_CH, 3: number of requesting channels (2..8).
- DECIMATION, 8: input samples consumed per output sample. Must match the engine.
- DATA_SIZE, 32: sample width in bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_empty  in  NUM_CH  per-channel input FIFO empty
- in_dout  in  NUM_CH*DATA_SIZE  per-channel input FIFO data; channel i occupies bits [i*DATA_SIZE +: DATA_SIZE]
- in_rd_en  out  NUM_CH  per-channel input FIFO read strobe
- out_full  in  NUM_CH  per-channel output FIFO full
- out_din  out  DATA_SIZE  shared write data to all output FIFOs
- out_wr_en  out  NUM_CH  per-channel output FIFO write strobe
- fir_x_din  out  DATA_SIZE  sample to engine
- fir_x_empty  out  1  engine input empty
- fir_x_rd_en  in  1  engine pops a sample
- fir_ch  out  $clog2(NUM_CH)  active channel; selects the engine history bank
- fir_y_dout  in  DATA_SIZE  engine output sample
- fir_y_wr_en  in  1  engine output valid
- fir_y_full  out  1  engine output back-pressure
- busy  out  1  high when not IDLE
- proto_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- States: IDLE, FEED, DRAIN. Held in registers g (granted channel), rr_ptr, and cnt (width $clog2(DECIMATION+1)).
- Reset values: state=IDLE, g=0, rr_ptr=0, cnt=0, proto_err=0.
- All strobes are 0 and fir_x_empty=fir_y_full=1 whenever state is IDLE, including immediately after reset.
- A channel i is eligible when in_empty[i]==0 and out_full[i]==0.
- IDLE:
  - Pick the first eligible channel starting at rr_ptr and wrapping modulo NUM_CH.
  - Next cycle: g=winner, cnt=0, state=FEED.
  - No eligible channel: remain in IDLE.
  - Grant latency is 1 cycle from eligibility.
- FEED (combinational pass-through):
  - fir_x_din=in_dout[g], fir_x_empty=in_empty[g], in_rd_en[g]=fir_x_rd_en & ~in_empty[g]; all other in_rd_en are 0.
  - Each accepted read increments cnt.
  - On the read that makes cnt==DECIMATION, transition to DRAIN.
  - If in_empty[g] rises mid-block, stall in FEED while holding the grant; never switch channel mid-block.
- DRAIN:
  - fir_x_empty=1, fir_y_full=out_full[g], out_din=fir_y_dout, out_wr_en[g]=fir_y_wr_en & ~out_full[g].
  - On an accepted write: rr_ptr=(g+1) mod NUM_CH, state=IDLE.
  - If out_full[g] is high, wait in DRAIN.
- fir_ch=g in all states. fir_ch changes only on an IDLE->FEED transition.
- Fairness: after serving channel g, every other eligible channel is served before g again.
- proto_err is set on either of:
  - fir_y_wr_en asserted in IDLE or FEED (output is dropped, no FIFO written);
  - fir_x_rd_en asserted while fir_x_empty=1.
- Minimum block time (no stalls, engine pops every cycle):
  - 1 cycle IDLE + DECIMATION cycles FEED + engine latency in DRAIN + 1 cycle.
  - The single-cycle IDLE between blocks is required.
- Reset mid-block: return to IDLE immediately. The partial block is abandoned; the engine is reset by the same signal.

Decomposition:
- Package fir_sched_pkg holds:
  - state enum (IDLE, FEED, DRAIN);
  - function ch_w(n)=$clog2(n) for channel-index width.
- One sub-module, rr_arbiter #(N):
  - inputs: req[N], ptr;
  - outputs: gnt_valid, gnt_idx;
  - purely combinational rotate-priority encode;
  - instantiated once in IDLE-decision logic.

Test Plan:
1. Reset, then all in_empty=1 -> busy=0, all strobes 0, fir_x_empty=1, fir_y_full=1, fir_ch=0 for 20 cycles.
2. NUM_CH=3, only ch1 non-empty with 8 samples 1..8; engine pops every cycle and returns 0xAB after 4 cycles -> fir_ch=1; exactly 8 in_rd_en[1] pulses; one out_wr_en[1] with out_din=0xAB; rr_ptr=2.
3. All 3 channels continuously eligible for 6 blocks -> grant order 0,1,2,0,1,2. Each channel receives exactly 2 outputs.
4. Ch0 in_empty asserted after 3 samples for 10 cycles; ch2 eligible -> grant stays ch0 (fir_ch=0). Remaining 5 samples are read after refill, then DRAIN. Ch2 is served only afterwards.
5. out_full[0]=1 during DRAIN for 5 cycles -> fir_y_full=1, out_wr_en=0. Write occurs the cycle out_full drops.
6. Spurious fir_y_wr_en in FEED -> proto_err=1 and held; no out_wr_en. Reset mid-FEED -> state IDLE next cycle, proto_err=0.
